// File: rtl/eo_scheduler.sv
// Two-requester round-robin scheduler that classifies each granted operand as even/odd.
// Optional delivered-result statistics are built only when EO_SCHEDULER_STATS_EN is defined.
module eo_scheduler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_num,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_num,
  output logic             b_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_num,
  output logic             rsp_even,
  output logic [CNT_W-1:0] even_cnt,
  output logic [CNT_W-1:0] odd_cnt
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic             r_id;
  logic [WIDTH-1:0] r_num;
  logic             r_even;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_rsp_hs;

  // Readies are gated by rst_n so they read 0 for the whole reset assertion.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n && a_valid && (!b_valid || !r_ptr)) begin
          w_grant_a   = 1'b1;
          w_state_nxt = CALC;
        end else if (rst_n && b_valid) begin
          w_grant_b   = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;
  assign rsp_valid = (r_state == RESP);
  assign w_rsp_hs  = rsp_valid && rsp_ready;
  assign rsp_id    = r_id;
  assign rsp_num   = r_num;
  assign rsp_even  = r_even;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_id    <= 1'b0;
      r_num   <= '0;
      r_even  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_a) begin
        r_num <= a_num;
        r_id  <= 1'b0;
        r_ptr <= 1'b1;
      end else if (w_grant_b) begin
        r_num <= b_num;
        r_id  <= 1'b1;
        r_ptr <= 1'b0;
      end
      if (r_state == CALC) r_even <= ~r_num[0];
    end
  end

`ifdef EO_SCHEDULER_STATS_EN
  logic [CNT_W-1:0] r_even_cnt;
  logic [CNT_W-1:0] r_odd_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_even_cnt <= '0;
      r_odd_cnt  <= '0;
    end else if (w_rsp_hs) begin
      if (r_even) r_even_cnt <= sat_inc(r_even_cnt);
      else        r_odd_cnt  <= sat_inc(r_odd_cnt);
    end
  end

  assign even_cnt = r_even_cnt;
  assign odd_cnt  = r_odd_cnt;
`else
  logic w_unused_hs;
  assign w_unused_hs = w_rsp_hs;
  assign even_cnt    = '0;
  assign odd_cnt     = '0;
`endif

endmodule

// File: tb/tb_eo_scheduler.sv
// Scoreboard bench for eo_scheduler: a reference model pushes expected results on
// each predicted grant and retires them on each response handshake.
module tb_eo_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0;
  logic       b_valid = 1'b0;
  logic       rsp_ready = 1'b0;
  logic [7:0] a_num = 8'd0;
  logic [7:0] b_num = 8'd0;

  logic        a_ready, b_ready, rsp_valid, rsp_id, rsp_even;
  logic [7:0]  rsp_num;
  logic [15:0] even_cnt, odd_cnt;

  logic        a_ready2, b_ready2, rsp_valid2, rsp_id2, rsp_even2;
  logic [7:0]  rsp_num2;
  logic [1:0]  even_cnt2, odd_cnt2;

  int checks = 0;
  int errors = 0;

  eo_scheduler #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_num(a_num), .a_ready(a_ready),
    .b_valid(b_valid), .b_num(b_num), .b_ready(b_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_num(rsp_num), .rsp_even(rsp_even),
    .even_cnt(even_cnt), .odd_cnt(odd_cnt)
  );

  // Narrow-counter copy sharing all inputs, used for saturation.
  eo_scheduler #(.WIDTH(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_num(a_num), .a_ready(a_ready2),
    .b_valid(b_valid), .b_num(b_num), .b_ready(b_ready2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2),
    .rsp_num(rsp_num2), .rsp_even(rsp_even2),
    .even_cnt(even_cnt2), .odd_cnt(odd_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic [7:0] num;
    logic       even;
  } rsp_t;

  rsp_t        sb[$];
  rsp_t        m_tmp;
  logic [1:0]  m_st = 2'd0;
  logic        m_ptr = 1'b0;
  logic [15:0] m_even = 16'd0;
  logic [15:0] m_odd = 16'd0;
  logic [1:0]  m_odd2 = 2'd0;

  // Reference model: 0 = idle, 1 = classify, 2 = respond.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st   <= 2'd0;
      m_ptr  <= 1'b0;
      m_even <= 16'd0;
      m_odd  <= 16'd0;
      m_odd2 <= 2'd0;
      sb.delete();
    end else begin
      case (m_st)
        2'd0: begin
          if (a_valid && (!b_valid || !m_ptr)) begin
            m_tmp.id = 1'b0; m_tmp.num = a_num; m_tmp.even = ~a_num[0];
            sb.push_back(m_tmp);
            m_ptr <= 1'b1;
            m_st  <= 2'd1;
          end else if (b_valid) begin
            m_tmp.id = 1'b1; m_tmp.num = b_num; m_tmp.even = ~b_num[0];
            sb.push_back(m_tmp);
            m_ptr <= 1'b0;
            m_st  <= 2'd1;
          end
        end
        2'd1: m_st <= 2'd2;
        default: begin
          if (rsp_ready) begin
            m_st <= 2'd0;
            if (sb.size() > 0) begin
`ifdef EO_SCHEDULER_STATS_EN
              if (sb[0].even) begin
                m_even <= (m_even == 16'hFFFF) ? m_even : m_even + 16'd1;
              end else begin
                m_odd  <= (m_odd == 16'hFFFF) ? m_odd : m_odd + 16'd1;
                m_odd2 <= (m_odd2 == 2'd3) ? m_odd2 : m_odd2 + 2'd1;
              end
`endif
              void'(sb.pop_front());
            end
          end
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b1;
    a_num = 8'd7;
    #1;
    checks++;
    if ({a_ready, b_ready, rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_handshake: got %b expected 000", {a_ready, b_ready, rsp_valid});
    end
    checks++;
    if ({rsp_id, rsp_num, rsp_even} !== 10'd0) begin
      errors++;
      $display("FAIL reset_rsp_fields: got id=%0d num=%0d even=%0d expected 0 0 0", rsp_id, rsp_num, rsp_even);
    end
    checks++;
    if (even_cnt !== 16'd0 || odd_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got even=%0d odd=%0d expected 0 0", even_cnt, odd_cnt);
    end
    step();
    a_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_a();
    step();
    a_valid = 1'b1; a_num = 8'd10; rsp_ready = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: got a_ready=%b b_ready=%b expected 1 0", a_ready, b_ready);
    end
    step();
    a_valid = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_calc: got a_ready=%b rsp_valid=%b expected 0 0", a_ready, rsp_valid);
    end
    step();
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || {rsp_id, rsp_num, rsp_even} !== {1'b0, 8'd10, 1'b1}) begin
      errors++;
      $display("FAIL single_rsp: got v=%b id=%0d num=%0d even=%0d expected 1 0 10 1", rsp_valid, rsp_id, rsp_num, rsp_even);
    end
    checks++;
    if (sb.size() == 0 || {rsp_id, rsp_num, rsp_even} !== sb[0]) begin
      errors++;
      $display("FAIL single_sb: got %h expected %h (queue %0d)", {rsp_id, rsp_num, rsp_even}, (sb.size() > 0) ? sb[0] : 10'h0, sb.size());
    end
    step();
    #1;
    checks++;
`ifdef EO_SCHEDULER_STATS_EN
    if (even_cnt !== 16'd1 || even_cnt !== m_even) begin
`else
    if (even_cnt !== 16'd0 || even_cnt !== m_even) begin
`endif
      errors++;
      $display("FAIL single_even_cnt: got %0d expected %0d", even_cnt, m_even);
    end
  endtask

  task automatic test_alternate();
    int g[$];
    int evs[$];
    int nresp;
    int exp_g[3];
    int exp_e[3];
    exp_g = '{0, 1, 0};
    exp_e = '{0, 1, 0};
    nresp = 0;
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; a_num = 8'd3; b_num = 8'd128; rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nresp < 3; cyc++) begin
      #1;
      checks++;
      if (a_ready && b_ready) begin
        errors++;
        $display("FAIL alt_both_ready: got 11 expected at most one");
      end
      if (a_ready) g.push_back(0);
      if (b_ready) g.push_back(1);
      if (rsp_valid) begin
        checks++;
        if (sb.size() == 0 || {rsp_id, rsp_num, rsp_even} !== sb[0]) begin
          errors++;
          $display("FAIL alt_sb: got %h expected %h (queue %0d)", {rsp_id, rsp_num, rsp_even}, (sb.size() > 0) ? sb[0] : 10'h0, sb.size());
        end
        evs.push_back(int'(rsp_even));
        nresp++;
      end
      step();
      if (g.size() >= 3) begin
        a_valid = 1'b0; b_valid = 1'b0;
      end
    end
    checks++;
    if (nresp != 3 || g.size() != 3) begin
      errors++;
      $display("FAIL alt_count: got resp=%0d grants=%0d expected 3 3", nresp, g.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < g.size() && i < evs.size()) begin
        checks++;
        if (g[i] != exp_g[i] || evs[i] != exp_e[i]) begin
          errors++;
          $display("FAIL alt_order[%0d]: got id=%0d even=%0d expected %0d %0d", i, g[i], evs[i], exp_g[i], exp_e[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] odd_before;
    b_valid = 1'b1; b_num = 8'd255; rsp_ready = 1'b0;
    #1;
    checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_grant: got a_ready=%b b_ready=%b expected 0 1", a_ready, b_ready);
    end
    step();
    b_valid = 1'b0; a_valid = 1'b1; a_num = 8'd4;
    step();
    odd_before = m_odd;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_id, rsp_num, rsp_even} !== {1'b1, 8'd255, 1'b0} ||
          a_ready !== 1'b0 || b_ready !== 1'b0 || odd_cnt !== odd_before) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d num=%0d even=%0d rdy=%b%b odd=%0d expected 1 1 255 0 00 %0d",
                 i, rsp_valid, rsp_id, rsp_num, rsp_even, a_ready, b_ready, odd_cnt, odd_before);
      end
      step();
    end
    rsp_ready = 1'b1; a_valid = 1'b0;
    step();
    #1;
    checks++;
`ifdef EO_SCHEDULER_STATS_EN
    if (odd_cnt !== odd_before + 16'd1 || odd_cnt !== m_odd || rsp_valid !== 1'b0) begin
`else
    if (odd_cnt !== 16'd0 || odd_cnt !== m_odd || rsp_valid !== 1'b0) begin
`endif
      errors++;
      $display("FAIL bp_release: got odd=%0d v=%b expected odd=%0d v=0", odd_cnt, rsp_valid, m_odd);
    end
  endtask

  task automatic test_reset_mid();
    step();
    a_valid = 1'b1; a_num = 8'd2; rsp_ready = 1'b0;
    step();
    a_valid = 1'b0;
    step();
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_num !== 8'd2) begin
      errors++;
      $display("FAIL mid_resp: got v=%b num=%0d expected 1 2", rsp_valid, rsp_num);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_num !== 8'd0 || even_cnt !== 16'd0 || odd_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b num=%0d even=%0d odd=%0d expected 0 0 0 0", rsp_valid, rsp_num, even_cnt, odd_cnt);
    end
    step();
    rst_n = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; a_num = 8'd5; b_num = 8'd6;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_next_grant: got a_ready=%b b_ready=%b expected 1 0", a_ready, b_ready);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    step();
    step();
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL mid_lost_req: got v=%b queue=%0d expected 0 0", rsp_valid, sb.size());
    end
  endtask

  task automatic test_saturation();
    int ops[5];
    int expo[5];
    ops  = '{1, 3, 5, 7, 9};
    expo = '{1, 2, 3, 3, 3};
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_valid = 1'b1; a_num = 8'(ops[k]);
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
        errors++;
        $display("FAIL sat_grant[%0d]: got %b expected 1", k, a_ready);
      end
      step();
      a_valid = 1'b0;
      step();
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_num !== 8'(ops[k]) || rsp_even !== 1'b0) begin
        errors++;
        $display("FAIL sat_rsp[%0d]: got v=%b num=%0d even=%0d expected 1 %0d 0", k, rsp_valid, rsp_num, rsp_even, ops[k]);
      end
      step();
      #1;
      checks++;
`ifdef EO_SCHEDULER_STATS_EN
      if (odd_cnt2 !== 2'(expo[k]) || odd_cnt2 !== m_odd2 || odd_cnt !== m_odd) begin
`else
      if (odd_cnt2 !== 2'd0 || odd_cnt2 !== m_odd2 || odd_cnt !== m_odd || expo[k] == 0) begin
`endif
        errors++;
        $display("FAIL sat_cnt[%0d]: got odd2=%0d odd=%0d expected odd2=%0d odd=%0d", k, odd_cnt2, odd_cnt, m_odd2, m_odd);
      end
    end
  endtask

  task automatic test_even_odd();
    logic [7:0] vals[2];
    logic       exp_e[2];
    vals  = '{8'd0, 8'd1};
    exp_e = '{1'b1, 1'b0};
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a_valid = 1'b1; a_num = vals[k];
      step();
      a_valid = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL eo_calc[%0d]: got v=%b expected 0", k, rsp_valid);
      end
      step();
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_even !== exp_e[k] || sb.size() == 0 ||
          {rsp_id, rsp_num, rsp_even} !== sb[0]) begin
        errors++;
        $display("FAIL eo_rsp[%0d]: got v=%b even=%b num=%0d expected 1 %b %0d", k, rsp_valid, rsp_even, rsp_num, exp_e[k], vals[k]);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_even_odd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
